// File: rtl/traffic_request_generator_if.sv
// Request/handshake bundle between board I/O, the request generator and the traffic controller.
`default_nettype none

interface traffic_request_generator_if #(
  parameter int NUM_PED = 4,
  parameter int LANES   = 8
);
  logic [NUM_PED-1:0] pedButton;
  logic [LANES-1:0]   emgDetect;
  logic               tick;
  logic               pedAck;
  logic               emgClear;
  logic               timeSignal;
  logic               pedSignal;
  logic               emgSignal;
  logic [LANES-1:0]   emgLane;

  modport master (
    output pedButton, emgDetect, tick, pedAck, emgClear,
    input  timeSignal, pedSignal, emgSignal, emgLane
  );

  modport slave (
    input  pedButton, emgDetect, tick, pedAck, emgClear,
    output timeSignal, pedSignal, emgSignal, emgLane
  );
endinterface

`default_nettype wire

// File: rtl/traffic_request_generator.sv
// +----------------------------------------------------------------------------+
// | traffic_request_generator: debounced ped/emergency requests, round-robin   |
// | emergency grant, day/night schedule. Option macro: TRG_EMG_TIMEOUT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module traffic_request_generator #(
  parameter int NUM_PED     = 4,
  parameter int LANES       = 8,
  parameter int DEB_CYCLES  = 4,
  parameter int DAY_TICKS   = 12,
  parameter int NIGHT_TICKS = 6,
  parameter int EMG_TIMEOUT = 10
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  traffic_request_generator_if.slave bus
);
  localparam int NIN  = NUM_PED + LANES;
  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int RRW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int MAXT = (DAY_TICKS > NIGHT_TICKS) ? DAY_TICKS : NIGHT_TICKS;
  localparam int SW   = $clog2(MAXT + 1);

  typedef enum logic [0:0] {
    NIGHT = 1'b0,
    DAY   = 1'b1
  } sched_e;

  logic [NIN-1:0]     raw;
  logic [NIN-1:0]     db;
  logic [NIN-1:0]     evt;
  logic [NUM_PED-1:0] evt_ped;
  logic [LANES-1:0]   evt_emg;

  assign raw     = {bus.emgDetect, bus.pedButton};
  assign evt_ped = evt[NUM_PED-1:0];
  assign evt_emg = evt[NIN-1:NUM_PED];

  // Per input: 2-flop synchronizer, saturating run counter, rising-edge detect on db.
  for (genvar g = 0; g < NIN; g++) begin : g_cond
    logic          s1_q, s1_d, s2_q, s2_d, dbp_q, dbp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d  = raw[g];
      s2_d  = s1_q;
      dbp_d = db[g];
      cnt_d = '0;
      if (s2_q) begin
        cnt_d = (cnt_q == CW'(DEB_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        dbp_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        dbp_q <= dbp_d;
        cnt_q <= cnt_d;
      end
    end

    assign db[g]  = (cnt_q == CW'(DEB_CYCLES));
    assign evt[g] = db[g] & ~dbp_q;
  end

  sched_e           sched_q, sched_d;
  logic [SW-1:0]    sc_q, sc_d;
  logic             ped_q, ped_d;
  logic             emg_q, emg_d;
  logic [LANES-1:0] lane_q, lane_d;
  logic [LANES-1:0] req_q, req_d;
  logic [RRW-1:0]   rr_q, rr_d;
  logic             found;
  logic [RRW-1:0]   sel;
  logic             grant;
  logic             release_now;
  logic             timeout_hit;

  // Round-robin scan starting at rr_q, wrapping past LANES-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!found && req_q[(int'(rr_q) + k) % LANES]) begin
        found = 1'b1;
        sel   = RRW'((int'(rr_q) + k) % LANES);
      end
    end
  end

  assign grant       = !emg_q && found;
  assign release_now = emg_q && (bus.emgClear || timeout_hit);

`ifdef TRG_EMG_TIMEOUT_EN
  localparam int AW = $clog2(EMG_TIMEOUT + 1);
  logic [AW-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (grant) begin
      age_d = '0;
    end else if (emg_q && bus.tick) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign timeout_hit = emg_q && bus.tick && (age_q == AW'(EMG_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    sched_d = sched_q;
    sc_d    = sc_q;
    if (bus.tick) begin
      if (sched_q == DAY && sc_q == SW'(DAY_TICKS - 1)) begin
        sched_d = NIGHT;
        sc_d    = '0;
      end else if (sched_q == NIGHT && sc_q == SW'(NIGHT_TICKS - 1)) begin
        sched_d = DAY;
        sc_d    = '0;
      end else begin
        sc_d = sc_q + 1'b1;
      end
    end

    // A fresh event outranks a same-cycle acknowledge.
    ped_d = (|evt_ped) ? 1'b1 : (bus.pedAck ? 1'b0 : ped_q);

    emg_d  = emg_q;
    lane_d = lane_q;
    rr_d   = rr_q;
    req_d  = req_q;
    if (release_now) begin
      req_d  = req_q & ~lane_q;
      emg_d  = 1'b0;
      lane_d = '0;
    end else if (grant) begin
      emg_d  = 1'b1;
      lane_d = {{(LANES-1){1'b0}}, 1'b1} << sel;
      rr_d   = (sel == RRW'(LANES - 1)) ? '0 : sel + 1'b1;
    end
    // Applied after the clear so a same-cycle event on the granted lane re-arms it.
    req_d = req_d | evt_emg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sched_q <= DAY;
      sc_q    <= '0;
      ped_q   <= 1'b0;
      emg_q   <= 1'b0;
      lane_q  <= '0;
      req_q   <= '0;
      rr_q    <= '0;
    end else begin
      sched_q <= sched_d;
      sc_q    <= sc_d;
      ped_q   <= ped_d;
      emg_q   <= emg_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.timeSignal = (sched_q == DAY);
  assign bus.pedSignal  = ped_q;
  assign bus.emgSignal  = emg_q;
  assign bus.emgLane    = lane_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_request_generator.sv
// Bench for traffic_request_generator: spec-level model checked every cycle plus literal checkpoints.
`default_nettype none

module tb_traffic_request_generator;
  localparam int NUM_PED = 4;
  localparam int LANES   = 8;
  localparam int DEB     = 4;
  localparam int DAYT    = 12;
  localparam int NIGHTT  = 6;
  localparam int EMGTO   = 10;
  localparam int NIN     = NUM_PED + LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_request_generator_if #(.NUM_PED(NUM_PED), .LANES(LANES)) bus ();

  traffic_request_generator #(
    .NUM_PED(NUM_PED), .LANES(LANES), .DEB_CYCLES(DEB),
    .DAY_TICKS(DAYT), .NIGHT_TICKS(NIGHTT), .EMG_TIMEOUT(EMGTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: raw run lengths, 3-stage event delay (sync + debounce edge), request/grant rules.
  bit             m_time = 1'b1, m_ped = 1'b0, m_emg = 1'b0;
  logic [7:0]     m_lane = '0, m_req = '0;
  int             m_rr = 0, m_sc = 0, m_age = 0;
  int             run [NIN];
  logic [NIN-1:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;

  always @(posedge clk) begin : model
    logic [NIN-1:0] raw_v, now_ev, new_ev;
    bit             rel, fnd;
    int             idx;
    if (rst) begin
      m_time = 1'b1; m_ped = 1'b0; m_emg = 1'b0; m_lane = '0; m_req = '0;
      m_rr = 0; m_sc = 0; m_age = 0;
      pipe0 = '0; pipe1 = '0; pipe2 = '0;
      for (int i = 0; i < NIN; i++) run[i] = 0;
    end else begin
      raw_v  = {bus.emgDetect, bus.pedButton};
      now_ev = pipe2;
      pipe2  = pipe1;
      pipe1  = pipe0;
      for (int i = 0; i < NIN; i++) begin
        run[i]    = raw_v[i] ? run[i] + 1 : 0;
        new_ev[i] = (run[i] == DEB);
      end
      pipe0 = new_ev;

      if (bus.tick) begin
        m_sc++;
        if (m_time && m_sc == DAYT) begin
          m_time = 1'b0; m_sc = 0;
        end else if (!m_time && m_sc == NIGHTT) begin
          m_time = 1'b1; m_sc = 0;
        end
      end

      if (|now_ev[NUM_PED-1:0]) m_ped = 1'b1;
      else if (bus.pedAck)      m_ped = 1'b0;

      rel = m_emg && bus.emgClear;
`ifdef TRG_EMG_TIMEOUT_EN
      if (m_emg && bus.tick) begin
        m_age++;
        if (m_age == EMGTO) rel = 1'b1;
      end
`endif
      if (rel) begin
        m_req  = m_req & ~m_lane;
        m_emg  = 1'b0;
        m_lane = '0;
      end else if (!m_emg && m_req != 0) begin
        fnd = 1'b0;
        for (int k = 0; k < LANES; k++) begin
          idx = (m_rr + k) % LANES;
          if (!fnd && m_req[idx]) begin
            fnd    = 1'b1;
            m_emg  = 1'b1;
            m_lane = 8'h01 << idx;
            m_rr   = (idx + 1) % LANES;
            m_age  = 0;
          end
        end
      end
      m_req = m_req | now_ev[NIN-1:NUM_PED];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model.timeSignal", {7'd0, bus.timeSignal}, {7'd0, m_time});
      chk("model.pedSignal",  {7'd0, bus.pedSignal},  {7'd0, m_ped});
      chk("model.emgSignal",  {7'd0, bus.emgSignal},  {7'd0, m_emg});
      chk("model.emgLane",    bus.emgLane,            m_lane);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1; cyc(1);
      bus.tick = 1'b0; cyc(1);
    end
  endtask

  initial begin
    bus.pedButton = '0; bus.emgDetect = '0; bus.tick = 1'b0;
    bus.pedAck = 1'b0;  bus.emgClear = 1'b0;

    // Reset
    rst = 1'b1;
    cyc(1);
    check_en = 1'b1;
    cyc(1);
    chk("rst.time", {7'd0, bus.timeSignal}, 8'h01);
    chk("rst.ped",  {7'd0, bus.pedSignal},  8'h00);
    chk("rst.emg",  {7'd0, bus.emgSignal},  8'h00);
    chk("rst.lane", bus.emgLane,            8'h00);
    rst = 1'b0;

    // Pedestrian: glitch, latency, ack, hold-once
    bus.pedButton[2] = 1'b1; cyc(3);
    bus.pedButton[2] = 1'b0; cyc(8);
    chk("ped.glitch", {7'd0, bus.pedSignal}, 8'h00);
    bus.pedButton[2] = 1'b1; cyc(6);
    chk("ped.edge6", {7'd0, bus.pedSignal}, 8'h00);
    cyc(1);
    chk("ped.edge7", {7'd0, bus.pedSignal}, 8'h01);
    cyc(2);
    bus.pedAck = 1'b1; cyc(1); bus.pedAck = 1'b0;
    chk("ped.ack", {7'd0, bus.pedSignal}, 8'h00);
    cyc(6);
    chk("ped.hold_once", {7'd0, bus.pedSignal}, 8'h00);
    bus.pedButton[2] = 1'b0; cyc(3);
    bus.pedButton[0] = 1'b1; cyc(6);
    bus.pedAck = 1'b1; cyc(1); bus.pedAck = 1'b0;
    chk("ped.ack_vs_event", {7'd0, bus.pedSignal}, 8'h01);
    bus.pedButton[0] = 1'b0;
    bus.pedAck = 1'b1; cyc(1); bus.pedAck = 1'b0;
    chk("ped.ack2", {7'd0, bus.pedSignal}, 8'h00);
    cyc(3);

    // Emergency arbitration and clear
    bus.emgDetect = 8'h24; cyc(7);
    chk("emg.edge7", {7'd0, bus.emgSignal}, 8'h00);
    cyc(1);
    chk("emg.first_grant", bus.emgLane, 8'h04);
    bus.emgDetect = 8'h00; cyc(2);
    bus.emgClear = 1'b1; cyc(1); bus.emgClear = 1'b0;
    chk("emg.idle_gap", bus.emgLane, 8'h00);
    cyc(1);
    chk("emg.second_grant", bus.emgLane, 8'h20);
    cyc(2);
    bus.emgClear = 1'b1; cyc(1); bus.emgClear = 1'b0;
    chk("emg.cleared", {7'd0, bus.emgSignal}, 8'h00);
    bus.emgClear = 1'b1; cyc(2); bus.emgClear = 1'b0;
    chk("emg.clear_idle", {7'd0, bus.emgSignal}, 8'h00);

    // Schedule
    pulse_ticks(11);
    chk("sched.day11", {7'd0, bus.timeSignal}, 8'h01);
    pulse_ticks(1);
    chk("sched.night", {7'd0, bus.timeSignal}, 8'h00);
    pulse_ticks(5);
    chk("sched.night5", {7'd0, bus.timeSignal}, 8'h00);
    pulse_ticks(1);
    chk("sched.day_again", {7'd0, bus.timeSignal}, 8'h01);
    pulse_ticks(5);
    rst = 1'b1; bus.tick = 1'b1; cyc(2);
    rst = 1'b0; bus.tick = 1'b0;
    chk("sched.rst_tick", {7'd0, bus.timeSignal}, 8'h01);
    pulse_ticks(11);
    chk("sched.cnt_cleared", {7'd0, bus.timeSignal}, 8'h01);
    pulse_ticks(1);
    chk("sched.night_after_rst", {7'd0, bus.timeSignal}, 8'h00);
    pulse_ticks(6);

    // Reset mid-grant: rrPtr is 0 after the reset above, lanes 0 and 7 pending
    bus.emgDetect = 8'h81; cyc(8);
    chk("emg.grant_81", bus.emgLane, 8'h01);
    bus.emgDetect = 8'h00; cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("rstgrant.emg",  {7'd0, bus.emgSignal},  8'h00);
    chk("rstgrant.lane", bus.emgLane,            8'h00);
    chk("rstgrant.time", {7'd0, bus.timeSignal}, 8'h01);
    cyc(15);
    chk("rstgrant.no_regrant", {7'd0, bus.emgSignal}, 8'h00);

    // Grant age / timeout
    bus.emgDetect = 8'h08; cyc(5);
    bus.emgDetect = 8'h00; cyc(4);
    chk("to.grant", bus.emgLane, 8'h08);
    pulse_ticks(9);
    chk("to.tick9", {7'd0, bus.emgSignal}, 8'h01);
    bus.tick = 1'b1; cyc(1); bus.tick = 1'b0;
`ifdef TRG_EMG_TIMEOUT_EN
    chk("to.tick10", {7'd0, bus.emgSignal}, 8'h00);
`else
    chk("to.tick10", {7'd0, bus.emgSignal}, 8'h01);
`endif
    cyc(1);
    pulse_ticks(10);
`ifdef TRG_EMG_TIMEOUT_EN
    chk("to.tick20", {7'd0, bus.emgSignal}, 8'h00);
`else
    chk("to.tick20", {7'd0, bus.emgSignal}, 8'h01);
`endif
    bus.emgClear = 1'b1; cyc(1); bus.emgClear = 1'b0;
    cyc(3);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
